// File: rtl/frac_divider_seq_pkg.sv
// Shared types and width helpers for the sequential fractional divider.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ITER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int q_width(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  function automatic int cnt_width(input int q_w);
    return $clog2(q_w + 1);
  endfunction

endpackage

// File: rtl/frac_divider_seq_if.sv
// Operand/result bundle for frac_divider_seq; master drives operands, slave is the divider.
interface frac_divider_seq_if
  import divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int INT_BITS  = 1,
  parameter int FRAC_BITS = 16,
  parameter int TAG_W     = 4
);
  localparam int Q_W = q_width(INT_BITS, FRAC_BITS);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_num;
  logic [WIDTH-1:0] i_den;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic             o_valid;
  logic [Q_W-1:0]   o_quot;
  logic [WIDTH-1:0] o_rem;
  logic [TAG_W-1:0] o_tag;
  logic             o_dz;
  logic             o_ovf;

  modport master (
    output i_valid, i_num, i_den, i_tag, i_flush,
    input  o_ready, o_valid, o_quot, o_rem, o_tag, o_dz, o_ovf
  );

  modport slave (
    input  i_valid, i_num, i_den, i_tag, i_flush,
    output o_ready, o_valid, o_quot, o_rem, o_tag, o_dz, o_ovf
  );

endinterface

// File: rtl/frac_divider_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;

  always_comb begin
    trial = {rem_in, bit_in};
    if (trial >= {2'b00, den}) begin
      q_bit   = 1'b1;
      // rem_in < den, so trial - den < den and the top bit can be dropped
      rem_out = trial[WIDTH:0] - {1'b0, den};
    end else begin
      q_bit   = 1'b0;
      rem_out = trial[WIDTH:0];
    end
  end

endmodule

// File: rtl/frac_divider_seq.sv
// Sequential restoring divider: quot = floor(num*2^FRAC_BITS/den), rem = (num*2^FRAC_BITS) mod den,
// with divide-by-zero / overflow saturation, flush and tag passthrough.
//
//   state    | meaning
//   IDLE     | ready, waiting for i_valid
//   CHECK    | classify operands (dz / ovf / normal), preload iteration registers
//   ITER     | one quotient bit per cycle, MSB first, Q_W cycles
//   DONE     | publish result registers, o_valid pulses on the following cycle
module frac_divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int INT_BITS  = 1,
  parameter int FRAC_BITS = 16,
  parameter int TAG_W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  frac_divider_seq_if.slave bus
);

  localparam int Q_W   = q_width(INT_BITS, FRAC_BITS);
  localparam int CNT_W = cnt_width(Q_W);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [Q_W-1:0]   shf_q, shf_d;
  logic [Q_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             valid_q, valid_d;
  logic [Q_W-1:0]   oquot_q, oquot_d;
  logic [WIDTH-1:0] orem_q, orem_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic             odz_q, odz_d;
  logic             oovf_q, oovf_d;

  logic [WIDTH+INT_BITS-1:0] num_ext;
  logic [WIDTH+INT_BITS-1:0] den_sh;
  logic [WIDTH:0]            step_rem;
  logic                      step_bit;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shf_q[Q_W-1]),
    .den     (den_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    tag_d   = tag_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    oquot_d = oquot_q;
    orem_d  = orem_q;
    otag_d  = otag_q;
    odz_d   = odz_q;
    oovf_d  = oovf_q;
    num_ext = {{INT_BITS{1'b0}}, num_q};
    den_sh  = {{INT_BITS{1'b0}}, den_q} << INT_BITS;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          num_d   = bus.i_num;
          den_d   = bus.i_den;
          tag_d   = bus.i_tag;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (den_q == '0) begin
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else if (num_ext >= den_sh) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          // upper numerator bits seed the remainder; the rest stream in with the fraction zeros
          rem_d   = {1'b0, num_q >> INT_BITS};
          shf_d   = {num_q[INT_BITS-1:0], {FRAC_BITS{1'b0}}};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        rem_d = step_rem;
        acc_d = {acc_q[Q_W-2:0], step_bit};
        shf_d = shf_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b1;
        oquot_d = (dz_q || ovf_q) ? '1 : acc_q;
        orem_d  = (dz_q || ovf_q) ? '0 : rem_q[WIDTH-1:0];
        otag_d  = tag_q;
        odz_d   = dz_q;
        oovf_d  = ovf_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // a flush abandons the operation and leaves the published result untouched
    if (bus.i_flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      oquot_d = oquot_q;
      orem_d  = orem_q;
      otag_d  = otag_q;
      odz_d   = odz_q;
      oovf_d  = oovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      tag_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
      shf_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      oquot_q <= '0;
      orem_q  <= '0;
      otag_q  <= '0;
      odz_q   <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      tag_q   <= tag_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      oquot_q <= oquot_d;
      orem_q  <= orem_d;
      otag_q  <= otag_d;
      odz_q   <= odz_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_quot  = oquot_q;
  assign bus.o_rem   = orem_q;
  assign bus.o_tag   = otag_q;
  assign bus.o_dz    = odz_q;
  assign bus.o_ovf   = oovf_q;

endmodule

// File: tb/tb_frac_divider_seq.sv
// Directed bench for frac_divider_seq: a 1.16 instance and a 4.8 instance side by side.
module tb_frac_divider_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frac_divider_seq_if #(.WIDTH(16), .INT_BITS(1), .FRAC_BITS(16), .TAG_W(4)) ia ();
  frac_divider_seq_if #(.WIDTH(16), .INT_BITS(4), .FRAC_BITS(8),  .TAG_W(4)) ib ();

  frac_divider_seq #(.WIDTH(16), .INT_BITS(1), .FRAC_BITS(16), .TAG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  frac_divider_seq #(.WIDTH(16), .INT_BITS(4), .FRAC_BITS(8), .TAG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int tests = 0;
  int fails = 0;

  logic [16:0] r_quot;
  logic [15:0] r_rem;
  logic [3:0]  r_tag;
  logic        r_dz, r_ovf, r_after;
  int          r_lat;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  // 4.8 reference: floor(num*256/den), saturating on dz / ovf
  function automatic void model_b(input longint num, input longint den,
                                  output longint q, output longint r,
                                  output bit dz, output bit ovf);
    dz = 1'b0; ovf = 1'b0; q = 0; r = 0;
    if (den == 0) begin
      dz = 1'b1; q = 'hFFF;
    end else if (num >= den * 16) begin
      ovf = 1'b1; q = 'hFFF;
    end else begin
      q = (num * 256) / den;
      r = (num * 256) % den;
    end
  endfunction

  task automatic run_op(input bit sel, input logic [15:0] num, input logic [15:0] den,
                        input logic [3:0] tag, input bit fl);
    int n;
    if (sel) begin
      ib.i_num = num; ib.i_den = den; ib.i_tag = tag; ib.i_flush = fl; ib.i_valid = 1'b1;
    end else begin
      ia.i_num = num; ia.i_den = den; ia.i_tag = tag; ia.i_flush = fl; ia.i_valid = 1'b1;
    end
    n = 0;
    while (((sel ? ib.o_ready : ia.o_ready) !== 1'b1) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    if (sel) begin ib.i_valid = 1'b0; ib.i_flush = 1'b0; end
    else begin ia.i_valid = 1'b0; ia.i_flush = 1'b0; end
    r_lat = 0;
    while (((sel ? ib.o_valid : ia.o_valid) !== 1'b1) && r_lat < 40) begin
      @(posedge clk); #1; r_lat++;
    end
    if (sel) begin
      r_quot = {5'b0, ib.o_quot}; r_rem = ib.o_rem; r_tag = ib.o_tag; r_dz = ib.o_dz; r_ovf = ib.o_ovf;
    end else begin
      r_quot = ia.o_quot; r_rem = ia.o_rem; r_tag = ia.o_tag; r_dz = ia.o_dz; r_ovf = ia.o_ovf;
    end
    @(posedge clk); #1;
    r_after = sel ? ib.o_valid : ia.o_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  tg [2];
    logic [16:0] qt [2];
    int          cy [2];
    int          pulses, vcount;
    bit          pend, rdy;
    logic [15:0] rn, rd;
    longint      mq, mr;
    bit          mdz, movf;

    ia.i_valid = 0; ia.i_num = 0; ia.i_den = 0; ia.i_tag = 0; ia.i_flush = 0;
    ib.i_valid = 0; ib.i_num = 0; ib.i_den = 0; ib.i_tag = 0; ib.i_flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ia.o_ready, 1);
    chk("rst_valid", ia.o_valid, 0);
    chk("rst_quot",  ia.o_quot, 0);
    chk("rst_flags", {ia.o_rem, ia.o_tag, ia.o_dz, ia.o_ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16'd3, 16'd4, 4'h1, 0);
    chk("3/4_quot", r_quot, 17'h0C000);
    chk("3/4_rem",  r_rem, 0);
    chk("3/4_tag",  r_tag, 4'h1);
    chk("3/4_lat",  r_lat, 19);
    chk("3/4_pulse", r_after, 0);
    chk("3/4_flags", {r_dz, r_ovf}, 0);

    run_op(0, 16'd5, 16'd5, 4'h3, 0);
    chk("5/5_quot", r_quot, 17'h10000);
    chk("5/5_rem",  r_rem, 0);

    run_op(0, 16'd7, 16'd2, 4'h4, 0);
    chk("ovf_flag", {r_dz, r_ovf}, 2'b01);
    chk("ovf_quot", r_quot, 17'h1FFFF);
    chk("ovf_rem",  r_rem, 0);
    chk("ovf_lat",  r_lat, 2);

    run_op(0, 16'd9, 16'd0, 4'h6, 0);
    chk("dz_flag", {r_dz, r_ovf}, 2'b10);
    chk("dz_quot", r_quot, 17'h1FFFF);
    chk("dz_rem",  r_rem, 0);
    chk("dz_lat",  r_lat, 2);
    chk("dz_tag",  r_tag, 4'h6);

    run_op(0, 16'd0, 16'd9, 4'h7, 1);
    chk("zero_flush_idle_quot", r_quot, 0);
    chk("zero_rem", r_rem, 0);
    chk("zero_tag", r_tag, 4'h7);
    chk("zero_lat", r_lat, 19);

    run_op(0, 16'd1, 16'd1, 4'h8, 0);
    chk("den1_quot", r_quot, 17'h10000);

    run_op(0, 16'hFFFD, 16'h7FFF, 4'h9, 0);
    chk("edge_quot", r_quot, 17'h1FFFD);
    chk("edge_rem",  r_rem, 16'h7FFD);
    chk("edge_ovf",  r_ovf, 0);

    run_op(0, 16'hFFFE, 16'h7FFF, 4'hB, 0);
    chk("edge_ovf_flag", r_ovf, 1);
    chk("edge_ovf_lat",  r_lat, 2);

    // back-to-back, second request held while busy
    ia.i_num = 16'd1; ia.i_den = 16'd2; ia.i_tag = 4'hA; ia.i_valid = 1'b1;
    @(posedge clk); #1;
    ia.i_num = 16'd3; ia.i_den = 16'd8; ia.i_tag = 4'h5;
    pulses = 0; pend = 1'b1;
    cy[0] = 0; cy[1] = 0; tg[0] = 0; tg[1] = 0; qt[0] = 0; qt[1] = 0;
    for (int c = 1; c <= 60; c++) begin
      rdy = ia.o_ready;
      @(posedge clk); #1;
      if (pend && rdy) begin ia.i_valid = 1'b0; pend = 1'b0; end
      if (ia.o_valid === 1'b1) begin
        if (pulses < 2) begin tg[pulses] = ia.o_tag; qt[pulses] = ia.o_quot; cy[pulses] = c; end
        pulses++;
      end
    end
    ia.i_valid = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_tag0", tg[0], 4'hA);
    chk("b2b_tag1", tg[1], 4'h5);
    chk("b2b_quot0", qt[0], 17'h08000);
    chk("b2b_quot1", qt[1], 17'h06000);
    chk("b2b_lat0", cy[0], 19);
    chk("b2b_gap", cy[1] - cy[0], 20);

    run_op(0, 16'd1, 16'd3, 4'h2, 0);
    chk("1/3_quot", r_quot, 17'h05555);
    chk("1/3_rem",  r_rem, 1);

    // flush at ITER step 8
    ia.i_num = 16'd3; ia.i_den = 16'd4; ia.i_tag = 4'hC; ia.i_valid = 1'b1;
    @(posedge clk); #1;
    ia.i_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    ia.i_flush = 1'b1;
    @(posedge clk); #1;
    ia.i_flush = 1'b0;
    chk("flush_ready", ia.o_ready, 1);
    vcount = 0;
    for (int c = 0; c < 25; c++) begin
      if (ia.o_valid === 1'b1) vcount++;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", vcount, 0);
    chk("flush_hold_quot", ia.o_quot, 17'h05555);
    chk("flush_hold_rem",  ia.o_rem, 1);
    chk("flush_hold_tag",  ia.o_tag, 4'h2);

    // async reset mid-ITER
    ia.i_num = 16'd5; ia.i_den = 16'd5; ia.i_tag = 4'hD; ia.i_valid = 1'b1;
    @(posedge clk); #1;
    ia.i_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_quot", ia.o_quot, 0);
    chk("rst_mid_tag",  {ia.o_tag, ia.o_rem}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_ready", ia.o_ready, 1);
    vcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (ia.o_valid === 1'b1) vcount++;
    end
    chk("rst_no_valid", vcount, 0);

    // 4.8 instance
    run_op(1, 16'd100, 16'd7, 4'h1, 0);
    chk("b_100/7_quot", r_quot, 17'h00E49);
    chk("b_100/7_rem",  r_rem, 1);
    chk("b_100/7_lat",  r_lat, 14);

    run_op(1, 16'd13, 16'd1, 4'h2, 0);
    chk("b_den1_quot", r_quot, 17'h00D00);
    chk("b_den1_rem",  r_rem, 0);

    run_op(1, 16'd16, 16'd1, 4'h3, 0);
    chk("b_ovf_flag", {r_dz, r_ovf}, 2'b01);
    chk("b_ovf_quot", r_quot, 17'h00FFF);

    for (int k = 0; k < 8; k++) begin
      rn = 16'($urandom_range(0, 65535));
      rd = 16'($urandom_range(0, 4095));
      model_b(longint'(rn), longint'(rd), mq, mr, mdz, movf);
      run_op(1, rn, rd, 4'(k), 0);
      chk("b_rand_quot", r_quot, mq);
      chk("b_rand_rem",  r_rem, mr);
      chk("b_rand_flags", {r_dz, r_ovf}, {mdz, movf});
      chk("b_rand_lat", r_lat, (mdz || movf) ? 2 : 14);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
